// File: rtl/obstacle_collision_scorer_pkg.sv
// Shared types and constants for the obstacle collision / scoring block.
// Holds the game-state encoding, sprite IDs that can collide, hitbox half-sizes and BCD width.
package obstacle_collision_scorer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } state_t;

   localparam logic [3:0] ID_WALK_LO = 4'd6;
   localparam logic [3:0] ID_WALK_HI = 4'd7;
   localparam logic [3:0] ID_PROJ    = 4'd8;

   localparam logic [9:0] HIT_HALF_Y = 10'd32;
   localparam logic [9:0] HIT_HALF_X = 10'd24;

   localparam int BCD_DIGITS = 4;
   localparam int BCD_W      = 4 * BCD_DIGITS;

endpackage

// File: rtl/obstacle_collision_scorer_bcd_counter4.sv
// Four-digit BCD incrementer that saturates at 9999, with synchronous clear.
// o_lands_mul10 flags that the increment requested this clock produces a multiple of ten.
module bcd_counter4
   import obstacle_collision_scorer_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   input  logic             i_clear,
   input  logic             i_inc,
   output logic [BCD_W-1:0] o_value,
   output logic             o_lands_mul10
);

   logic [BCD_W-1:0] r_value;
   logic [BCD_W-1:0] w_next;
   logic             w_sat;
   logic             w_incr;

   assign w_sat  = (r_value == 16'h9999);
   assign w_incr = i_inc && !w_sat;

   always_comb begin : p_next
      logic v_carry;
      w_next  = r_value;
      v_carry = 1'b1;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (v_carry) begin
            if (r_value[i*4 +: 4] == 4'd9) begin
               w_next[i*4 +: 4] = 4'd0;
            end else begin
               w_next[i*4 +: 4] = r_value[i*4 +: 4] + 4'd1;
               v_carry          = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_value <= '0;
      end else if (i_clear) begin
         r_value <= '0;
      end else if (w_incr) begin
         r_value <= w_next;
      end
   end

   assign o_value       = r_value;
   assign o_lands_mul10 = w_incr && (r_value[3:0] == 4'd9);

endmodule

// File: rtl/obstacle_collision_scorer.sv
// Collision detection, BCD score/high score, speed feedback and RUN/HIT/OVER sequencing.
// Everything except start handling is sampled on frameTick.
module obstacle_collision_scorer
   import obstacle_collision_scorer_pkg::*;
#(
   parameter int HIT_TICKS      = 3,
   parameter int SPEED_INIT     = 2,
   parameter int SPEED_MAX      = 8,
   parameter int SPEED_STEP_PTS = 10
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             frameTick,
   input  logic             start,
   input  logic [7:0]       xObstacle,
   input  logic [8:0]       yObstacle,
   input  logic [3:0]       IdObstacle,
   input  logic             passed,
   input  logic [7:0]       xPlayer,
   input  logic [8:0]       yPlayer,
   output logic [8:0]       gameSpeed,
   output logic [BCD_W-1:0] score,
   output logic [BCD_W-1:0] highScore,
   output logic             running,
   output logic             hitFlash,
   output logic             gameOver,
   output logic             obstacleReset,
   output logic [1:0]       o_dbg_state
);

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_hit_cnt;
   logic             r_passed_prev;
   logic [8:0]       r_speed;
   logic [BCD_W-1:0] r_high;
   logic             r_obst_reset;

   logic [9:0]       w_dy, w_dx;
   logic             w_id_ok, w_hit, w_pass_edge;
   logic             w_start_game, w_score_inc, w_enter_hit, w_hit_done;
   logic             w_mul10, w_step, w_high_gt;
   logic [BCD_W-1:0] w_score;

   // Larger-minus-smaller keeps the distance unsigned with no wrap.
   assign w_dy = (yObstacle >= yPlayer) ? ({1'b0, yObstacle} - {1'b0, yPlayer})
                                        : ({1'b0, yPlayer} - {1'b0, yObstacle});
   assign w_dx = (xObstacle >= xPlayer) ? ({2'b0, xObstacle} - {2'b0, xPlayer})
                                        : ({2'b0, xPlayer} - {2'b0, xObstacle});
   assign w_id_ok     = (IdObstacle == ID_WALK_LO) || (IdObstacle == ID_WALK_HI) ||
                        (IdObstacle == ID_PROJ);
   assign w_hit       = w_id_ok && (w_dy < HIT_HALF_Y) && (w_dx < HIT_HALF_X);
   assign w_pass_edge = passed && !r_passed_prev;

   always_comb begin
      w_state_nxt  = r_state;
      w_start_game = 1'b0;
      w_score_inc  = 1'b0;
      w_enter_hit  = 1'b0;
      w_hit_done   = 1'b0;
      case (r_state)
         ST_IDLE, ST_OVER: begin
            if (start) begin
               w_start_game = 1'b1;
               w_state_nxt  = ST_RUN;
            end
         end
         ST_RUN: begin
            if (frameTick) begin
               if (w_hit) begin
                  w_enter_hit = 1'b1;
                  w_state_nxt = ST_HIT;
               end else if (w_pass_edge) begin
                  w_score_inc = 1'b1;
               end
            end
         end
         ST_HIT: begin
            if (frameTick && (r_hit_cnt == 8'(HIT_TICKS - 1))) begin
               w_hit_done  = 1'b1;
               w_state_nxt = ST_OVER;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   bcd_counter4 u_score (
      .clock         (clock),
      .reset         (reset),
      .i_clear       (w_start_game),
      .i_inc         (w_score_inc),
      .o_value       (w_score),
      .o_lands_mul10 (w_mul10)
   );

   // The BCD counter's decade flag covers the common step of ten; other steps keep a binary modulus.
   generate
      if (SPEED_STEP_PTS == 10) begin : g_step_dec
         assign w_step = w_mul10;
      end else begin : g_step_mod
         logic [15:0] r_pts_mod;
         logic        w_incr;
         assign w_incr = w_score_inc && (w_score != 16'h9999);
         assign w_step = w_incr && (r_pts_mod == 16'(SPEED_STEP_PTS - 1));
         always_ff @(posedge clock or posedge reset) begin
            if (reset)             r_pts_mod <= '0;
            else if (w_start_game) r_pts_mod <= '0;
            else if (w_step)       r_pts_mod <= '0;
            else if (w_incr)       r_pts_mod <= r_pts_mod + 16'd1;
         end
      end
   endgenerate

   always_comb begin : p_high_cmp
      logic v_done;
      w_high_gt = 1'b0;
      v_done    = 1'b0;
      for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
         if (!v_done && (w_score[i*4 +: 4] != r_high[i*4 +: 4])) begin
            w_high_gt = (w_score[i*4 +: 4] > r_high[i*4 +: 4]);
            v_done    = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_hit_cnt     <= '0;
         r_passed_prev <= 1'b0;
         r_speed       <= 9'(SPEED_INIT);
         r_high        <= '0;
         r_obst_reset  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_obst_reset <= w_start_game;
         if (w_start_game) begin
            r_passed_prev <= 1'b0;
            r_speed       <= 9'(SPEED_INIT);
         end else if ((r_state == ST_RUN) && frameTick) begin
            r_passed_prev <= passed;
            if (w_step && (r_speed < 9'(SPEED_MAX))) r_speed <= r_speed + 9'd1;
         end
         if (w_enter_hit) begin
            r_hit_cnt <= '0;
         end else if ((r_state == ST_HIT) && frameTick && !w_hit_done) begin
            r_hit_cnt <= r_hit_cnt + 8'd1;
         end
         if (w_hit_done && w_high_gt) r_high <= w_score;
      end
   end

   assign gameSpeed     = r_speed;
   assign score         = w_score;
   assign highScore     = r_high;
   assign running       = (r_state == ST_RUN);
   assign hitFlash      = (r_state == ST_HIT);
   assign gameOver      = (r_state == ST_OVER);
   assign obstacleReset = r_obst_reset;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_obstacle_collision_scorer.sv
// Randomized and directed stimulus for obstacle_collision_scorer, checked every clock
// against a reference model that tracks score and high score as plain integers.
module tb_obstacle_collision_scorer;

   localparam int HIT_TICKS      = 3;
   localparam int SPEED_INIT     = 2;
   localparam int SPEED_MAX      = 8;
   localparam int SPEED_STEP_PTS = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_HIT = 2, M_OVER = 3;

   logic        clock = 1'b0;
   logic        reset;
   logic        frameTick, start, passed;
   logic [7:0]  xObstacle, xPlayer;
   logic [8:0]  yObstacle, yPlayer;
   logic [3:0]  IdObstacle;
   logic [8:0]  gameSpeed;
   logic [15:0] score, highScore;
   logic        running, hitFlash, gameOver, obstacleReset;
   logic [1:0]  o_dbg_state;

   int n_checks = 0;
   int n_fail   = 0;

   int m_mode, m_score, m_high, m_hit_ticks;
   bit m_prev, m_orst;

   always #5 clock = ~clock;

   obstacle_collision_scorer #(
      .HIT_TICKS(HIT_TICKS), .SPEED_INIT(SPEED_INIT),
      .SPEED_MAX(SPEED_MAX), .SPEED_STEP_PTS(SPEED_STEP_PTS)
   ) dut (
      .clock(clock), .reset(reset), .frameTick(frameTick), .start(start),
      .xObstacle(xObstacle), .yObstacle(yObstacle), .IdObstacle(IdObstacle),
      .passed(passed), .xPlayer(xPlayer), .yPlayer(yPlayer),
      .gameSpeed(gameSpeed), .score(score), .highScore(highScore),
      .running(running), .hitFlash(hitFlash), .gameOver(gameOver),
      .obstacleReset(obstacleReset), .o_dbg_state(o_dbg_state)
   );

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   function automatic int iabs(input int a);
      return (a < 0) ? -a : a;
   endfunction

   function automatic int exp_speed();
      int s;
      s = SPEED_INIT + m_score / SPEED_STEP_PTS;
      return (s > SPEED_MAX) ? SPEED_MAX : s;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_score = 0; m_high = 0; m_hit_ticks = 0;
      m_prev = 1'b0; m_orst = 1'b0;
   endtask

   // Advances the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      bit hit, rise, id_ok;
      m_orst = 1'b0;
      if (m_mode == M_IDLE || m_mode == M_OVER) begin
         if (start) begin
            m_score = 0; m_prev = 1'b0; m_mode = M_RUN; m_orst = 1'b1;
         end
      end else if (m_mode == M_RUN) begin
         if (frameTick) begin
            id_ok = (IdObstacle == 6) || (IdObstacle == 7) || (IdObstacle == 8);
            hit   = id_ok && (iabs(int'(yObstacle) - int'(yPlayer)) < 32) &&
                    (iabs(int'(xObstacle) - int'(xPlayer)) < 24);
            rise  = passed && !m_prev;
            m_prev = passed;
            if (hit) begin
               m_mode = M_HIT; m_hit_ticks = 0;
            end else if (rise && m_score < 9999) begin
               m_score++;
            end
         end
      end else if (frameTick) begin
         m_hit_ticks++;
         if (m_hit_ticks == HIT_TICKS) begin
            m_mode = M_OVER;
            if (m_score > m_high) m_high = m_score;
         end
      end
   endtask

   task automatic check_all();
      check_eq("score", score, to_bcd(m_score));
      check_eq("highScore", highScore, to_bcd(m_high));
      check_eq("gameSpeed", gameSpeed, exp_speed());
      check_eq("running", running, m_mode == M_RUN);
      check_eq("hitFlash", hitFlash, m_mode == M_HIT);
      check_eq("gameOver", gameOver, m_mode == M_OVER);
      check_eq("obstacleReset", obstacleReset, m_orst);
      check_eq("state", o_dbg_state, m_mode);
   endtask

   task automatic cycle(input bit ft, input bit st, input bit ps);
      @(negedge clock);
      frameTick = ft; start = st; passed = ps;
      @(posedge clock);
      #1;
      model_step();
      check_all();
   endtask

   task automatic far_positions();
      xObstacle  = 8'($urandom_range(0, 60));
      xPlayer    = 8'($urandom_range(100, 255));
      yObstacle  = 9'($urandom_range(0, 511));
      yPlayer    = 9'($urandom_range(0, 511));
      IdObstacle = 4'($urandom_range(0, 15));
   endtask

   task automatic near_positions();
      int xp, xo, yp, yo;
      xp = $urandom_range(60, 190);
      xo = xp + $urandom_range(0, 60) - 30;
      yp = $urandom_range(50, 450);
      yo = yp + $urandom_range(0, 80) - 40;
      if (xo < 0) xo = 0;
      if (xo > 255) xo = 255;
      if (yo < 0) yo = 0;
      if (yo > 511) yo = 511;
      xPlayer = 8'(xp); xObstacle = 8'(xo); yPlayer = 9'(yp); yObstacle = 9'(yo);
      IdObstacle = 4'($urandom_range(5, 9));
   endtask

   task automatic hit_positions(input logic [3:0] id);
      yObstacle = 9'd200; yPlayer = 9'd180; xObstacle = 8'd63; xPlayer = 8'd70;
      IdObstacle = id;
   endtask

   task automatic do_pass();
      far_positions();
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0);
   endtask

   task automatic async_reset();
      @(negedge clock);
      #2;
      reset = 1'b1; frameTick = 1'b0; start = 1'b0; passed = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; frameTick = 1'b0; start = 1'b0; passed = 1'b0;
      far_positions();
      model_reset();
      #1;
      check_all();
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Start a game, then 70 separated passes.
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("start_orst", obstacleReset, 1'b1);
      check_eq("start_speed", gameSpeed, 9'd2);
      cycle(1'b0, 1'b0, 1'b0);
      check_eq("orst_width", obstacleReset, 1'b0);
      for (int i = 1; i <= 70; i++) begin
         do_pass();
         if (i == 10) begin
            check_eq("score10", score, 16'h0010);
            check_eq("speed10", gameSpeed, 9'd3);
         end
         if (i == 60) check_eq("speed60", gameSpeed, 9'd8);
      end
      check_eq("score70", score, 16'h0070);
      check_eq("speed70", gameSpeed, 9'd8);

      // Collision, flash, game over.
      hit_positions(4'd6);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("hit_flash", hitFlash, 1'b1);
      repeat (2) cycle(1'b1, 1'b0, 1'b0);
      check_eq("still_flash", hitFlash, 1'b1);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("game_over", gameOver, 1'b1);
      check_eq("high70", highScore, 16'h0070);

      // Start together with frameTick in OVER: the tick is dropped, passedPrev cleared.
      far_positions();
      cycle(1'b1, 1'b1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1);
      check_eq("start_tick_score", score, 16'h0001);

      // Pass rising on the same tick as a hit.
      cycle(1'b1, 1'b0, 1'b0);
      hit_positions(4'd7);
      cycle(1'b1, 1'b0, 1'b1);
      check_eq("hit_wins_score", score, 16'h0001);
      check_eq("hit_wins_state", hitFlash, 1'b1);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);

      // Hitbox edges and non-colliding sprite ID.
      cycle(1'b0, 1'b1, 1'b0);
      yObstacle = 9'd100; yPlayer = 9'd132; xObstacle = 8'd50; xPlayer = 8'd50; IdObstacle = 4'd7;
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("dy32_nohit", running, 1'b1);
      yPlayer = 9'd69; xPlayer = 8'd73; IdObstacle = 4'd8;
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("dy31_dx23_hit", hitFlash, 1'b1);
      repeat (3) cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b1, 1'b0);
      hit_positions(4'd9);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("id9_nohit", running, 1'b1);

      // Randomized play.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) near_positions();
         else far_positions();
         cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0));
      end

      // Async reset while flashing, then a fresh game.
      cycle(1'b0, 1'b1, 1'b0);
      hit_positions(4'd6);
      cycle(1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("pre_reset_hit", hitFlash, 1'b1);
      async_reset();
      check_eq("rst_hitFlash", hitFlash, 1'b0);
      far_positions();
      cycle(1'b0, 1'b1, 1'b0);
      check_eq("post_rst_score", score, 16'h0000);
      check_eq("post_rst_high", highScore, 16'h0000);
      repeat (5) cycle(1'b1, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/obstacle_collision_scorer.md
# obstacle_collision_scorer

Consumer end of the obstacle update path. It samples the obstacle position, sprite ID and `passed` flag alongside the player position on every frame tick. From these it detects player/obstacle collisions and keeps a 4-digit BCD score and high score. It also generates the `gameSpeed` value fed back to the obstacle updater, and runs the RUN / HIT / OVER game-state sequence that drives the display and restart logic.

## Interface
Parameters:
- HIT_TICKS, 3: frame ticks spent in HIT (flash) before OVER.
- SPEED_INIT, 2: `gameSpeed` after reset or restart.
- SPEED_MAX, 8: saturation value of `gameSpeed`.
- SPEED_STEP_PTS, 10: points per `gameSpeed` increment.

Ports:
- clock, input, 1: system clock; all logic on rising edge.
- reset, input, 1: reset, asynchronous, active-high.
- frameTick, input, 1: one-clock pulse per obstacle update; all sampling happens on it.
- start, input, 1: one-clock pulse; starts or restarts a game.
- xObstacle, input, 8: obstacle vertical coordinate.
- yObstacle, input, 9: obstacle horizontal coordinate.
- IdObstacle, input, 4: sprite ID; 6/7 = low walker, 8 = high projectile.
- passed, input, 1: high for one update period when the obstacle leaves the screen.
- xPlayer, input, 8: player vertical coordinate.
- yPlayer, input, 9: player horizontal coordinate.
- gameSpeed, output, 9: obstacle step per update.
- score, output, 16: 4 BCD digits, current score.
- highScore, output, 16: 4 BCD digits, best score since reset.
- running, output, 1: high in RUN.
- hitFlash, output, 1: high in HIT.
- gameOver, output, 1: high in OVER.
- obstacleReset, output, 1: one-clock pulse to re-arm the obstacle updater's reset input.

## Operation
- States are IDLE, RUN, HIT and OVER. Reset enters IDLE.
- Reset values:
  - gameSpeed = SPEED_INIT.
  - score = 0, highScore = 0.
  - running, hitFlash, gameOver and obstacleReset = 0.
  - hitCnt = 0, passedPrev = 0.
- IDLE/OVER, on `start`:
  - score ← 0, gameSpeed ← SPEED_INIT, passedPrev ← 0.
  - Pulse obstacleReset for one clock.
  - Next state is RUN.
- RUN, on frameTick:
  - Collision: hit when |yObstacle − yPlayer| < 32 and |xObstacle − xPlayer| < 24.
  - Differences are computed unsigned at 10 bits via the larger-minus-smaller form. There is no wrap.
  - Scoring: when passed=1 and passedPrev=0, add 1 to score in BCD; 9999 saturates.
  - Speed: when an increment lands on a multiple of SPEED_STEP_PTS, gameSpeed ← min(gameSpeed+1, SPEED_MAX).
  - passedPrev ← passed on every tick.
  - If hit and pass occur on the same tick, the hit wins: the score does not change.
  - On hit: next state is HIT and hitCnt ← 0.
- HIT, on frameTick:
  - hitCnt increments each tick.
  - When hitCnt reaches HIT_TICKS−1, go to OVER and update highScore ← max(highScore, score), compared in BCD.
- OVER: outputs hold until `start`.
- `start` is ignored in RUN and HIT.
- Any IdObstacle outside {6,7,8} disables collision for that tick. Scoring still applies.

## Timing
- Registered outputs change the clock after the frameTick or start that causes them.
- Collision to hitFlash: 1 clock.
- hitFlash to gameOver: HIT_TICKS frame ticks.
- obstacleReset is exactly one clock wide, asserted the clock after `start`.
- frameTick and start on the same clock in IDLE/OVER: start is processed and the tick is ignored.
- Reset mid-game returns immediately (async) to IDLE with all reset values, highScore included.

## Structure
- Shared package holds:
  - state encoding (IDLE=0, RUN=1, HIT=2, OVER=3);
  - obstacle ID constants (6, 7, 8);
  - hitbox half-sizes (32, 24);
  - BCD width.
- Sub-module `bcd_counter4`: 4-digit saturating BCD incrementer with clear and an output flag "value is a multiple of 10". It is instantiated once for score. The highScore compare is a digit-wise magnitude comparator in the top module.

## Test plan
- Reset, then start → obstacleReset pulses 1 clock; running=1, score=0000, gameSpeed=2.
- 10 separated passed pulses (xPlayer far from xObstacle) → score=0010, gameSpeed=3. After 60 passes: gameSpeed=8, and the 70th pass leaves gameSpeed at 8.
- yObstacle=200, yPlayer=180, xObstacle=63, xPlayer=70, ID=6, frameTick → hitFlash next clock; gameOver after 3 ticks; highScore=score.
- Same tick carries passed rising and a hit → score unchanged, state HIT.
- Boundary: |Δy|=32 → no hit; |Δy|=31 with |Δx|=23 → hit. ID=9 with overlap → no hit.
- Reset asserted in HIT → outputs at reset values asynchronously; a subsequent start gives score=0000 and highScore=0000.
